collatz_search: RTL and testbench
=================================

COLLATZ_SEARCH -- requirements
Module: collatz_search

Interface
REQ-001 SHALL have parameter N_BITS, default 4: candidate width; search range 1..2^N_BITS-1.
REQ-002 SHALL have parameter VAL_W, default 12: internal trajectory value width.
REQ-003 SHALL have parameter STEP_W, default 5: target/step-count width.
REQ-004 SHALL have port clk  input  1: single clock, rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1: one-cycle request to begin a search; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1: cancels a running search.
REQ-008 SHALL have port target  input  STEP_W: required total stopping time; captured on the accepted start.
REQ-009 SHALL have port busy  output  1: high while a search runs.
REQ-010 SHALL have port done  output  1: one-cycle pulse when a search completes (not on abort).
REQ-011 SHALL have port found  output  1: result flag, held until the next accepted start.
REQ-012 SHALL have port n_out  output  N_BITS: smallest matching n; 0 when found=0; held like found.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE with start=1: capture target, set cand=1, val=1, steps=0, clear found and n_out, and enter RUN next cycle.
REQ-015 SHALL hold busy=1 in every RUN cycle and busy=0 otherwise.
REQ-016 SHALL, per RUN cycle with val!=1: set val to next value (even: val/2; odd: 3*val+1) and increment steps.
REQ-017 SHALL, per RUN cycle with val==1: on steps==target, latch found=1 and n_out=cand, then enter DONE.
REQ-018 SHALL, on val==1 mismatch with cand<2^N_BITS-1: load cand+1 into cand and val, clear steps, and stay in RUN.
REQ-019 SHALL, on val==1 mismatch with cand=2^N_BITS-1: enter DONE with found=0 and n_out=0.
REQ-020 SHALL treat a candidate as mismatched and advance per REQ-018/019 when 3*val+1 overflows VAL_W or steps would pass 2^STEP_W-1.
REQ-021 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-022 SHALL, on abort=1 in RUN, go to IDLE next cycle with found=0, n_out=0, and no done pulse.
REQ-023 SHALL ignore start outside IDLE; abort SHALL take priority over a simultaneous match.

Reset
REQ-024 SHALL, on reset, asynchronously force state=IDLE and busy, done, found, n_out, cand, val, steps (and cycles, if present) to 0.
REQ-025 SHALL, on reset mid-search, discard the search with no done pulse.

Configuration
REQ-026 SHALL, with COLLATZ_SEARCH_PERF_EN defined, add output cycles[15:0]: cleared on accepted start, incremented per RUN cycle, saturating at 0xFFFF, held after DONE.
REQ-027 SHALL, without COLLATZ_SEARCH_PERF_EN, omit the cycles port and its logic, with all other behaviour identical.

Structure
REQ-028 SHALL place the FSM state enum and the N_BITS/VAL_W/STEP_W default constants in shared package collatz_pkg.
REQ-029 SHALL instantiate combinational sub-module collatz_step (VAL_W in -> VAL_W next value plus overflow flag) for the single-step datapath.

Verification
REQ-030 SHALL cover: target=0, start -> done after 1 RUN cycle, found=1, n_out=1.
REQ-031 SHALL cover: target=7 -> found=1, n_out=3, 11 RUN cycles (cycles=11 with PERF_EN).
REQ-032 SHALL cover: target=9 -> found=1, n_out=12; target=19 -> found=1, n_out=9.
REQ-033 SHALL cover: target=4 -> range exhausted, done with found=0, n_out=0.
REQ-034 SHALL cover: abort 5 cycles after start -> busy drops next cycle, no done, found=0; new start then succeeds.
REQ-035 SHALL cover: reset mid-RUN -> all outputs 0 immediately; start during busy ignored, target change during RUN has no effect.

Source files
------------

// File: rtl/collatz_pkg.sv
// Shared types and default sizing for the Collatz stopping-time search.
package collatz_pkg;

  localparam int N_BITS_DEF = 4;
  localparam int VAL_W_DEF  = 12;
  localparam int STEP_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/collatz_step.sv
// One Collatz step: even -> val/2, odd -> 3*val+1.
// ovf flags an odd step whose result does not fit in VAL_W bits.
module collatz_step #(
  parameter int VAL_W = 12
) (
  input  logic [VAL_W-1:0] val,
  output logic [VAL_W-1:0] next_val,
  output logic             ovf
);

  // 3*val+1 computed two bits wider so the overflow is visible
  logic [VAL_W+1:0] triple;
  assign triple = {1'b0, val, 1'b0} + {2'b00, val} + {{(VAL_W+1){1'b0}}, 1'b1};

  // Pick the branch by parity
  always_comb begin
    next_val = {1'b0, val[VAL_W-1:1]};
    ovf      = 1'b0;
    if (val[0]) begin
      next_val = triple[VAL_W-1:0];
      ovf      = |triple[VAL_W+1:VAL_W];
    end
  end

endmodule

// File: rtl/collatz_search.sv
// Finds the smallest n in 1..2^N_BITS-1 whose total stopping time equals
// target. One Collatz step per RUN cycle. Define COLLATZ_SEARCH_PERF_EN to
// add a saturating 16-bit cycles counter of RUN cycles.
module collatz_search
  import collatz_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int VAL_W  = VAL_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] target,
  output logic              busy,
  output logic              done,
  output logic              found,
`ifdef COLLATZ_SEARCH_PERF_EN
  output logic [15:0]       cycles,
`endif
  output logic [N_BITS-1:0] n_out
);

  localparam logic [N_BITS-1:0] CAND_MAX  = {N_BITS{1'b1}};
  localparam logic [STEP_W-1:0] STEPS_MAX = {STEP_W{1'b1}};
  localparam logic [VAL_W-1:0]  VAL_ONE   = VAL_W'(1);

  state_t            state_reg, state_next;
  logic [N_BITS-1:0] cand_reg, cand_next;
  logic [VAL_W-1:0]  val_reg, val_next;
  logic [STEP_W-1:0] steps_reg, steps_next;
  logic [STEP_W-1:0] target_reg, target_next;
  logic              found_reg, found_next;
  logic [N_BITS-1:0] n_reg, n_next;
  logic              advance;
  logic [N_BITS-1:0] cand_inc;
  logic [VAL_W-1:0]  step_val;
  logic              step_ovf;
`ifdef COLLATZ_SEARCH_PERF_EN
  logic [15:0]       cycles_reg, cycles_next;
`endif

  collatz_step #(.VAL_W(VAL_W)) u_step (
    .val      (val_reg),
    .next_val (step_val),
    .ovf      (step_ovf)
  );

  assign cand_inc = cand_reg + N_BITS'(1);

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cand_reg   <= '0;
      val_reg    <= '0;
      steps_reg  <= '0;
      target_reg <= '0;
      found_reg  <= 1'b0;
      n_reg      <= '0;
`ifdef COLLATZ_SEARCH_PERF_EN
      cycles_reg <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      cand_reg   <= cand_next;
      val_reg    <= val_next;
      steps_reg  <= steps_next;
      target_reg <= target_next;
      found_reg  <= found_next;
      n_reg      <= n_next;
`ifdef COLLATZ_SEARCH_PERF_EN
      cycles_reg <= cycles_next;
`endif
    end
  end

  // Next-state and datapath decisions; abort outranks a match in RUN
  always_comb begin
    state_next  = state_reg;
    cand_next   = cand_reg;
    val_next    = val_reg;
    steps_next  = steps_reg;
    target_next = target_reg;
    found_next  = found_reg;
    n_next      = n_reg;
    advance     = 1'b0;
`ifdef COLLATZ_SEARCH_PERF_EN
    cycles_next = cycles_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          target_next = target;
          cand_next   = N_BITS'(1);
          val_next    = VAL_ONE;
          steps_next  = '0;
          found_next  = 1'b0;
          n_next      = '0;
          state_next  = RUN;
`ifdef COLLATZ_SEARCH_PERF_EN
          cycles_next = '0;
`endif
        end
      end
      RUN: begin
`ifdef COLLATZ_SEARCH_PERF_EN
        if (cycles_reg != 16'hFFFF) cycles_next = cycles_reg + 16'd1;
`endif
        if (abort) begin
          state_next = IDLE;
          found_next = 1'b0;
          n_next     = '0;
        end else if (val_reg == VAL_ONE) begin
          if (steps_reg == target_reg) begin
            found_next = 1'b1;
            n_next     = cand_reg;
            state_next = DONE;
          end else begin
            advance = 1'b1;
          end
        end else if (step_ovf || steps_reg == STEPS_MAX) begin
          // Trajectory left the representable range: give up on this n
          advance = 1'b1;
        end else begin
          val_next   = step_val;
          steps_next = steps_reg + STEP_W'(1);
        end
        if (advance) begin
          if (cand_reg != CAND_MAX) begin
            cand_next  = cand_inc;
            val_next   = VAL_W'(cand_inc);
            steps_next = '0;
          end else begin
            found_next = 1'b0;
            n_next     = '0;
            state_next = DONE;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);
  assign found = found_reg;
  assign n_out = n_reg;
`ifdef COLLATZ_SEARCH_PERF_EN
  assign cycles = cycles_reg;
`endif

endmodule

// File: tb/tb_collatz_search.sv
// Directed bench for collatz_search: a table of targets with hand-derived
// smallest n and RUN-cycle counts, plus abort / reset / ignored-start sequences.
module tb_collatz_search;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [4:0] target;
  logic       busy;
  logic       done;
  logic       found;
  logic [3:0] n_out;
`ifdef COLLATZ_SEARCH_PERF_EN
  logic [15:0] cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  collatz_search dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .target (target),
    .busy   (busy),
    .done   (done),
    .found  (found),
`ifdef COLLATZ_SEARCH_PERF_EN
    .cycles (cycles),
`endif
    .n_out  (n_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    int exp_found;
    int exp_n;
    int exp_cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start with tgt, then count RUN cycles until done (bounded)
  task automatic run_search(input int tgt, output int ncyc, output bit seen);
    target = 5'(tgt);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    ncyc   = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (busy) ncyc++;
      tick();
    end
    seen = done;
  endtask

  task automatic wait_done(output bit seen);
    for (int i = 0; i < 2000 && !done; i++) tick();
    seen = done;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_found"}, int'(found), 0);
    check({tag, "_n_out"}, int'(n_out), 0);
`ifdef COLLATZ_SEARCH_PERF_EN
    check({tag, "_cycles"}, int'(cycles), 0);
`endif
  endtask

  initial begin
    int  ncyc;
    bit  seen;
    bit  stray_done;

    // target, found, n, RUN cycles (sum of (steps+1) over n=1..match)
    vecs[0]  = '{0,  1, 1,  1};
    vecs[1]  = '{1,  1, 2,  3};
    vecs[2]  = '{2,  1, 4,  14};
    vecs[3]  = '{3,  1, 8,  50};
    vecs[4]  = '{5,  1, 5,  20};
    vecs[5]  = '{7,  1, 3,  11};
    vecs[6]  = '{9,  1, 12, 102};
    vecs[7]  = '{16, 1, 7,  46};
    vecs[8]  = '{17, 1, 14, 130};
    vecs[9]  = '{19, 1, 9,  70};
    vecs[10] = '{4,  0, 0,  148};

    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    target = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    reset = 1'b0;
    tick();

    foreach (vecs[k]) begin
      run_search(vecs[k].tgt, ncyc, seen);
      check("done_seen", int'(seen), 1);
      check("found", int'(found), vecs[k].exp_found);
      check("n_out", int'(n_out), vecs[k].exp_n);
      check("run_cycles", ncyc, vecs[k].exp_cyc);
`ifdef COLLATZ_SEARCH_PERF_EN
      check("cycles", int'(cycles), vecs[k].exp_cyc);
`endif
      $display("vec %0d: target=%0d found=%0d n_out=%0d run_cycles=%0d", k,
               vecs[k].tgt, found, n_out, ncyc);
      tick();
      check("done_pulse_len", int'(done), 0);
      check("busy_after", int'(busy), 0);
      check("found_held", int'(found), vecs[k].exp_found);
      check("n_out_held", int'(n_out), vecs[k].exp_n);
    end

    // Abort mid-search: busy drops, no done, results cleared
    target = 5'd19;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (4) tick();
    check("abort_pre_busy", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_found", int'(found), 0);
    check("abort_n_out", int'(n_out), 0);
    stray_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done || busy) stray_done = 1'b1;
      tick();
    end
    check("abort_no_done", int'(stray_done), 0);
    $display("abort: busy=%0d found=%0d n_out=%0d", busy, found, n_out);
    run_search(7, ncyc, seen);
    check("after_abort_seen", int'(seen), 1);
    check("after_abort_found", int'(found), 1);
    check("after_abort_n_out", int'(n_out), 3);
    check("after_abort_cycles", ncyc, 11);
    $display("restart after abort: target=7 found=%0d n_out=%0d", found, n_out);
    tick();

    // Start and target change while busy must not disturb the search
    target = 5'd9;
    start  = 1'b1;
    tick();
    target = 5'd0;
    repeat (3) tick();
    start = 1'b0;
    wait_done(seen);
    check("busy_start_seen", int'(seen), 1);
    check("busy_start_found", int'(found), 1);
    check("busy_start_n_out", int'(n_out), 12);
`ifdef COLLATZ_SEARCH_PERF_EN
    check("busy_start_cycles", int'(cycles), 102);
`endif
    $display("start during busy: target=9 found=%0d n_out=%0d", found, n_out);
    tick();

    // Reset in the middle of RUN clears everything without waiting for a clock
    target = 5'd9;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    check_idle_zero("midrun_reset");
    #1;
    reset = 1'b0;
    stray_done = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (done || busy) stray_done = 1'b1;
    end
    check("midrun_no_done", int'(stray_done), 0);
    $display("mid-run reset: busy=%0d found=%0d n_out=%0d", busy, found, n_out);

    run_search(0, ncyc, seen);
    check("post_reset_seen", int'(seen), 1);
    check("post_reset_found", int'(found), 1);
    check("post_reset_n_out", int'(n_out), 1);
    check("post_reset_cycles", ncyc, 1);
    $display("after reset: target=0 found=%0d n_out=%0d", found, n_out);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
